i2c_burst_reg_engine: RTL and testbench

Parametrised successor to the BMP180 low-level sequencer. Drives the existing byte-level I2C master handshake (start/send/datasend/sended/receive/datareceive/received) to run one of two transactions:
- burst read of 1..MAX_LEN consecutive registers from a configurable device address into an internal buffer;
- single-register write.
Sits between sensor-control FSMs (e.g. BMP180 calibration/measurement sequencer) and the I2C master. Adds a per-handshake timeout, error reporting and a random-access readout port.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_edge_det.sv | 20 ++
 rtl/i2c_burst_reg_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_burst_reg_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst register engine.
// Provides the engine state type, the I2C R/W address bit values,
// BMP180 register constants and a helper to form the address byte.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_CMD,
      ST_RECV,
      ST_FIN
   } state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [6:0] BMP180_ADDR      = 7'h77;
   localparam logic [7:0] BMP180_ID_REG    = 8'hD0;
   localparam logic [7:0] BMP180_CTRL_REG  = 8'hF4;
   localparam logic [7:0] BMP180_CALIB_REG = 8'hAA;
   localparam int         BMP180_CALIB_LEN = 22;

   // Address byte as it goes on the wire: 7-bit slave address then R/W.
   function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
      return {dev, rw};
   endfunction

endpackage

// File: rtl/i2c_edge_det.sv
// Registered rising-edge detector.
// Ports: clk_i / reset_i (sync, active high), sig_i level input,
//        rise_o high for the cycle in which sig_i is 1 and was 0 last cycle.
module i2c_edge_det (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) prev_q <= 1'b0;
      else         prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/i2c_burst_reg_engine.sv
// Burst register read / single register write engine on top of a
// byte-level I2C master handshake.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_i, wr_mode_i          request strobe, 0 = burst read, 1 = single write
//   reg_addr_i, wr_data_i     first register address, write byte
//   len_i                     burst read length (1..MAX_LEN)
//   busy_o, done_o, err_o     status; done/err are one-cycle pulses
//   rd_idx_i, rd_data_o       random-access readout of the receive buffer
//   start_o, send_o, datasend_o, sended_i              master write side
//   receive_o, datareceive_i, received_i               master read side
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for req, length check on read requests
// LOAD    | build command list, reset pointer/count
// START   | hold start high for START_HOLD cycles
// CMD     | send address, register, address/data bytes on sended rises
// RECV    | capture bytes into buffer on received rises
// FIN     | pulse done, drop busy
module i2c_burst_reg_engine
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = BMP180_ADDR,
   parameter int         MAX_LEN    = BMP180_CALIB_LEN,
   parameter int         START_HOLD = 64,
   parameter int         TIMEOUT    = 65535,
   parameter int         LEN_W      = $clog2(MAX_LEN + 1),
   parameter int         IDX_W      = $clog2(MAX_LEN)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req_i,
   input  logic             wr_mode_i,
   input  logic [7:0]       reg_addr_i,
   input  logic [7:0]       wr_data_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [7:0]       rd_data_o,
   output logic             start_o,
   output logic             send_o,
   output logic [7:0]       datasend_o,
   input  logic             sended_i,
   output logic             receive_o,
   input  logic [7:0]       datareceive_i,
   input  logic             received_i
);

   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

   state_e           state_q;
   logic             busy_q, done_q, err_q, start_q, send_q, receive_q;
   logic [7:0]       datasend_q;
   logic [1:0]       ptr_q;
   logic [LEN_W-1:0] count_q, len_q;
   logic [TMR_W-1:0] timer_q;
   logic [HOLD_W-1:0] hold_q;
   logic             wr_mode_q;
   logic [7:0]       reg_addr_q, wr_data_q;
   logic [7:0]       cmd_q [3];
   logic [7:0]       buf_q [MAX_LEN];

   logic sended_rise, received_rise, tmo_hit, len_bad;

   i2c_edge_det u_sended_det (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .sig_i  (sended_i),
      .rise_o (sended_rise)
   );

   i2c_edge_det u_received_det (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .sig_i  (received_i),
      .rise_o (received_rise)
   );

   // Hit on the cycle the timer would reach TIMEOUT: err lands TIMEOUT
   // cycles after the last handled edge.
   assign tmo_hit = (timer_q == TMR_W'(TIMEOUT - 1));
   assign len_bad = (len_i == '0) || (len_i > LEN_W'(MAX_LEN));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         send_q     <= 1'b0;
         receive_q  <= 1'b0;
         datasend_q <= 8'h00;
         ptr_q      <= '0;
         count_q    <= '0;
         len_q      <= '0;
         timer_q    <= '0;
         hold_q     <= '0;
         wr_mode_q  <= 1'b0;
         reg_addr_q <= 8'h00;
         wr_data_q  <= 8'h00;
         for (int i = 0; i < 3; i++)       cmd_q[i] <= 8'h00;
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'h00;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  wr_mode_q  <= wr_mode_i;
                  reg_addr_q <= reg_addr_i;
                  wr_data_q  <= wr_data_i;
                  len_q      <= len_i;
                  if (!wr_mode_i && len_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               ptr_q      <= '0;
               count_q    <= '0;
               cmd_q[0]   <= addr_byte(DEV_ADDR, RW_WRITE);
               cmd_q[1]   <= reg_addr_q;
               cmd_q[2]   <= wr_mode_q ? wr_data_q : addr_byte(DEV_ADDR, RW_READ);
               datasend_q <= addr_byte(DEV_ADDR, RW_WRITE);
               hold_q     <= HOLD_W'(START_HOLD - 1);
               start_q    <= 1'b1;
               state_q    <= ST_START;
            end
            ST_START: begin
               if (hold_q == '0) begin
                  start_q <= 1'b0;
                  timer_q <= '0;
                  state_q <= ST_CMD;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            ST_CMD: begin
               if (sended_rise) begin
                  ptr_q   <= ptr_q + 1'b1;
                  timer_q <= '0;
                  case (ptr_q)
                     2'd0: begin
                        send_q     <= 1'b1;
                        datasend_q <= cmd_q[1];
                     end
                     2'd1: begin
                        send_q     <= 1'b1;
                        datasend_q <= cmd_q[2];
                     end
                     default: begin
                        send_q <= 1'b0;
                        if (wr_mode_q) begin
                           state_q <= ST_FIN;
                        end else begin
                           receive_q <= 1'b1;
                           state_q   <= ST_RECV;
                        end
                     end
                  endcase
               end else if (tmo_hit) begin
                  err_q     <= 1'b1;
                  busy_q    <= 1'b0;
                  send_q    <= 1'b0;
                  receive_q <= 1'b0;
                  timer_q   <= TMR_W'(TIMEOUT);
                  state_q   <= ST_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            ST_RECV: begin
               if (received_rise) begin
                  buf_q[count_q] <= datareceive_i;
                  count_q        <= count_q + 1'b1;
                  timer_q        <= '0;
                  // NACK the last byte: receive drops with the final strobe.
                  if ((count_q + 1'b1) == len_q) begin
                     receive_q <= 1'b0;
                     state_q   <= ST_FIN;
                  end
               end else if (tmo_hit) begin
                  err_q     <= 1'b1;
                  busy_q    <= 1'b0;
                  send_q    <= 1'b0;
                  receive_q <= 1'b0;
                  timer_q   <= TMR_W'(TIMEOUT);
                  state_q   <= ST_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            ST_FIN: begin
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               send_q    <= 1'b0;
               receive_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign start_o    = start_q;
   assign send_o     = send_q;
   assign receive_o  = receive_q;
   assign datasend_o = datasend_q;

   assign rd_data_o = ({1'b0, rd_idx_i} < (IDX_W + 1)'(MAX_LEN)) ? buf_q[rd_idx_i] : 8'h00;

endmodule

// File: tb/tb_i2c_burst_reg_engine.sv
// Scoreboard bench for i2c_burst_reg_engine: the stimulus pushes expected
// bytes/events/readouts into queues, a negedge monitor pops and compares.
module tb_i2c_burst_reg_engine;
   import i2c_pkg::*;

   localparam int SH = 8;
   localparam int TO = 100;
   localparam int ML = 22;
   localparam int LW = $clog2(ML + 1);
   localparam int IW = $clog2(ML);
   localparam logic [1:0] EV_DONE = 2'b01;
   localparam logic [1:0] EV_ERR  = 2'b10;

   logic          clk = 1'b0;
   logic          reset, req, wr_mode, sended, received;
   logic [7:0]    reg_addr, wr_data, datareceive;
   logic [LW-1:0] len;
   logic [IW-1:0] rd_idx;
   logic          busy_o, done_o, err_o, start_o, send_o, receive_o;
   logic [7:0]    rd_data_o, datasend_o;

   always #5 clk = ~clk;

   i2c_burst_reg_engine #(
      .DEV_ADDR(7'h77), .MAX_LEN(ML), .START_HOLD(SH), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .wr_mode_i(wr_mode),
      .reg_addr_i(reg_addr), .wr_data_i(wr_data), .len_i(len),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .rd_idx_i(rd_idx), .rd_data_o(rd_data_o),
      .start_o(start_o), .send_o(send_o), .datasend_o(datasend_o), .sended_i(sended),
      .receive_o(receive_o), .datareceive_i(datareceive), .received_i(received)
   );

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
      bit          tmo;
   } chk_t;

   logic [7:0] exp_tx[$];
   bit         exp_rx[$];
   logic [1:0] exp_evt[$];
   logic [7:0] exp_rd[$];
   chk_t       chk_q[$];

   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  start_run = 0;
   int  start_falls = 0;
   int  st_high_cnt = 0;
   int  rx_high_cnt = 0;
   logic snd_prev = 1'b0;
   logic rcv_prev = 1'b0;
   logic rd_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string n, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
      end
   endfunction

   function automatic void report_fail(string n, logic [31:0] a);
      tests++;
      fails++;
      $display("FAIL %s: unexpected or timed out, value 0x%0h", n, a);
   endfunction

   // Monitor: the only place comparisons are made.
   always @(negedge clk) begin
      chk_t c;
      if (sended && !snd_prev) begin
         if (exp_tx.size() == 0) report_fail("tx_unexpected", {24'b0, datasend_o});
         else check("tx_byte", {24'b0, datasend_o}, {24'b0, exp_tx.pop_front()});
      end
      if (received && !rcv_prev) begin
         if (exp_rx.size() == 0) report_fail("rx_unexpected", {31'b0, receive_o});
         else check("rx_level", {31'b0, receive_o}, {31'b0, exp_rx.pop_front()});
      end
      if (done_o || err_o) begin
         if (exp_evt.size() == 0) report_fail("evt_unexpected", {30'b0, err_o, done_o});
         else check("evt", {30'b0, err_o, done_o}, {30'b0, exp_evt.pop_front()});
      end
      if (rd_chk) begin
         if (exp_rd.size() == 0) report_fail("rd_unexpected", {24'b0, rd_data_o});
         else check("rd_data", {24'b0, rd_data_o}, {24'b0, exp_rd.pop_front()});
      end
      if (start_o) begin
         start_run   <= start_run + 1;
         st_high_cnt <= st_high_cnt + 1;
      end else if (start_run != 0) begin
         check("start_hold", start_run, SH);
         start_run   <= 0;
         start_falls <= start_falls + 1;
      end
      if (receive_o) rx_high_cnt <= rx_high_cnt + 1;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         if (c.tmo) report_fail(c.name, c.act);
         else check(c.name, c.act, c.exp);
      end
      snd_prev <= sended;
      rcv_prev <= received;
   end

   task automatic push_chk(string n, logic [31:0] a, logic [31:0] e);
      chk_q.push_back('{n, a, e, 1'b0});
   endtask

   task automatic push_tmo(string n, logic [31:0] a);
      chk_q.push_back('{n, a, 32'h0, 1'b1});
   endtask

   task automatic do_req(input logic wm, input logic [7:0] ra, input logic [7:0] wd, input int n);
      @(posedge clk); #1;
      req = 1'b1; wr_mode = wm; reg_addr = ra; wr_data = wd; len = LW'(n);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_cmd();
      int n = 0;
      while (!start_o && n < 50) begin @(negedge clk); n++; end
      while (start_o && n < 200) begin @(negedge clk); n++; end
      if (n >= 200 || !(n > 0 || start_o == 1'b0)) push_tmo("wait_start", n);
   endtask

   task automatic slot(output int t_evt);
      @(posedge clk); #1 sended = 1'b1;
      @(negedge clk); t_evt = cyc + 1;
      repeat (2) @(posedge clk);
      #1 sended = 1'b0;
      @(posedge clk);
   endtask

   task automatic rbyte(input logic [7:0] d);
      @(posedge clk); #1 datareceive = d; received = 1'b1;
      repeat (2) @(posedge clk);
      #1 received = 1'b0;
      @(posedge clk);
   endtask

   task automatic wait_idle(string n);
      int k = 0;
      while (busy_o && k < 300) begin @(negedge clk); k++; end
      if (busy_o) push_tmo(n, k);
      repeat (2) @(negedge clk);
   endtask

   task automatic rd_check(input int idx, input logic [7:0] e);
      @(posedge clk); #1;
      rd_idx = IW'(idx);
      exp_rd.push_back(e);
      rd_chk = 1'b1;
      @(posedge clk); #1 rd_chk = 1'b0;
   endtask

   task automatic run_read(input logic [7:0] addr, input int n, input logic [7:0] d0);
      int t;
      exp_tx.push_back(8'hEE); exp_tx.push_back(addr); exp_tx.push_back(8'hEF);
      for (int i = 0; i < n; i++) exp_rx.push_back(1'b1);
      exp_evt.push_back(EV_DONE);
      do_req(1'b0, addr, 8'h00, n);
      wait_cmd();
      repeat (3) slot(t);
      for (int i = 0; i < n; i++) rbyte(d0 + 8'(i));
      push_chk("rx_low_after_last", {31'b0, receive_o}, 0);
      wait_idle("read_done_wait");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
      $fatal(1);
   end

   initial begin
      int t, t_last, r0, s0, k;
      reset = 1'b1; req = 1'b0; wr_mode = 1'b0; sended = 1'b0; received = 1'b0;
      reg_addr = 8'h00; wr_data = 8'h00; datareceive = 8'h00; len = '0; rd_idx = '0;
      repeat (3) @(posedge clk); #1;
      push_chk("rst_flags", {26'b0, busy_o, done_o, err_o, start_o, send_o, receive_o}, 0);
      push_chk("rst_datasend", {24'b0, datasend_o}, 0);
      reset = 1'b0;
      rd_check(3, 8'h00);

      // Read chip ID, single byte.
      run_read(BMP180_ID_REG, 1, 8'h55);
      rd_check(0, 8'h55);

      // Full calibration burst, data = index.
      run_read(BMP180_CALIB_REG, 22, 8'h00);
      for (int i = 0; i < 22; i++) rd_check(i, 8'(i));
      rd_check(22, 8'h00);
      rd_check(31, 8'h00);

      // Single write to ctrl register.
      exp_tx.push_back(8'hEE); exp_tx.push_back(8'hF4); exp_tx.push_back(8'h2E);
      exp_evt.push_back(EV_DONE);
      @(posedge clk); #1 r0 = rx_high_cnt;
      do_req(1'b1, BMP180_CTRL_REG, 8'h2E, 0);
      wait_cmd();
      slot(t); slot(t);
      push_chk("wr_busy_mid", {31'b0, busy_o}, 1);
      slot(t);
      wait_idle("write_done_wait");
      push_chk("wr_no_receive", rx_high_cnt - r0, 0);

      // Master stalls after the second byte.
      exp_tx.push_back(8'hEE); exp_tx.push_back(8'hD0);
      exp_evt.push_back(EV_ERR);
      do_req(1'b0, BMP180_ID_REG, 8'h00, 1);
      wait_cmd();
      slot(t); slot(t_last);
      k = 0;
      while (!err_o && k < TO + 50) begin @(negedge clk); k++; end
      if (!err_o) push_tmo("tmo_wait", k);
      else begin
         push_chk("tmo_latency", cyc - t_last, TO);
         push_chk("tmo_outs", {28'b0, busy_o, start_o, send_o, receive_o}, 0);
      end
      repeat (2) @(negedge clk);
      run_read(BMP180_ID_REG, 1, 8'hA5);
      rd_check(0, 8'hA5);

      // Illegal lengths.
      foreach (exp_rd[i]) ;
      for (int j = 0; j < 2; j++) begin
         exp_evt.push_back(EV_ERR);
         @(posedge clk); #1 s0 = st_high_cnt;
         do_req(1'b0, BMP180_ID_REG, 8'h00, (j == 0) ? 0 : 23);
         push_chk((j == 0) ? "badlen0_err" : "badlen23_err", {31'b0, err_o}, 1);
         repeat (SH + 4) @(posedge clk); #1;
         push_chk((j == 0) ? "badlen0_nostart" : "badlen23_nostart", st_high_cnt - s0, 0);
         push_chk((j == 0) ? "badlen0_busy" : "badlen23_busy", {31'b0, busy_o}, 0);
      end

      // Requests while busy are dropped.
      exp_tx.push_back(8'hEE); exp_tx.push_back(8'hF4); exp_tx.push_back(8'h2E);
      exp_evt.push_back(EV_DONE);
      do_req(1'b1, BMP180_CTRL_REG, 8'h2E, 0);
      do_req(1'b0, 8'h11, 8'h00, 3);
      wait_cmd();
      slot(t);
      do_req(1'b0, 8'h22, 8'h00, 2);
      slot(t); slot(t);
      wait_idle("overlap_done_wait");

      // Reset in the middle of a burst after five bytes.
      exp_tx.push_back(8'hEE); exp_tx.push_back(8'hAA); exp_tx.push_back(8'hEF);
      for (int i = 0; i < 5; i++) exp_rx.push_back(1'b1);
      do_req(1'b0, BMP180_CALIB_REG, 8'h00, 10);
      wait_cmd();
      repeat (3) slot(t);
      for (int i = 0; i < 5; i++) rbyte(8'h80 + 8'(i));
      push_chk("mid_busy_before_rst", {31'b0, busy_o}, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      push_chk("mid_rst_flags", {26'b0, busy_o, done_o, err_o, start_o, send_o, receive_o}, 0);
      push_chk("mid_rst_datasend", {24'b0, datasend_o}, 0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) rd_check(i, 8'h00);

      repeat (3) @(negedge clk);
      push_chk("sb_drain", exp_tx.size() + exp_rx.size() + exp_evt.size() + exp_rd.size(), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
